// File: rtl/sp_ram_loader.sv
// Single-port synchronous RAM filled by a valid/ready burst loader,
// then read like a ROM table with one-cycle registered read data.
module sp_ram_loader #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len_c;
  logic              wr;
  logic [DATA_W-1:0] mem [DEPTH];

  assign len_c = (len > DEPTH_C) ? DEPTH_C : len;
  assign wr    = (state == LOAD) && in_valid && in_ready;

  // Burst sequencer with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wptr     <= '0;
      cnt      <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            wptr <= start_addr;
            cnt  <= len_c;
            if (len_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (wr) begin
            wptr <= wptr + 1'b1;
            cnt  <= cnt - 1'b1;
            if (cnt == ONE_C) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Storage: cleared by reset, written only by accepted burst words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr) begin
      mem[wptr] <= in_data;
    end
  end

  // Read port: the writer owns the array while a burst is loading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (en && (state != LOAD)) begin
      data_out <= mem[addr];
    end
  end

endmodule

// File: tb/tb_sp_ram_loader.sv
// Directed bench for sp_ram_loader: burst loads, wrap, stalls,
// edge lengths, port collisions and asynchronous reset.
module tb_sp_ram_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] start_addr;
  logic [3:0] len;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       en;
  logic [2:0] addr;
  logic [3:0] data_out;

  int checks = 0;
  int errors = 0;
  int acc;
  int cyc;
  logic [3:0] wq [$];
  logic [3:0] t2 [8];

  sp_ram_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .en         (en),
    .addr       (addr),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, input logic [3:0] e);
    en   = 1'b1;
    addr = a;
    tick();
    en = 1'b0;
    check($sformatf("rd_addr%0d", a), data_out, e);
  endtask

  task automatic burst(input logic [2:0] sa, input logic [3:0] ln,
                       input int gap);
    int i;
    int stall;
    i     = 0;
    stall = 0;
    acc   = 0;
    cyc   = 0;
    start      = 1'b1;
    start_addr = sa;
    len        = ln;
    tick();
    start = 1'b0;
    while (!done && cyc < 64) begin
      if (in_ready && stall == 0) begin
        in_valid = 1'b1;
        in_data  = wq[i % wq.size()];
        i++;
        acc++;
        stall = gap;
      end else begin
        in_valid = 1'b0;
        in_data  = 4'hE;
        if (stall > 0) stall--;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    check("rdy_at_done", in_ready, 0);
    tick();
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    en         = 1'b0;
    addr       = '0;
    t2 = '{4'h1, 4'h3, 4'hA, 4'h6, 4'h7, 4'hD, 4'h9, 4'hB};

    #3;
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic load of all eight words
    wq = '{4'h1, 4'h3, 4'hA, 4'h6, 4'h7, 4'hD, 4'h9, 4'hB};
    burst(3'd0, 4'd8, 0);
    check("t2_accepts", acc, 8);
    check("t2_cycles", cyc, 8);
    for (int a = 0; a < 8; a++) rd(3'(a), t2[a]);

    // asynchronous reset with no clock edge
    #2 rst_n = 1'b0;
    #1;
    check("async_data", data_out, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    #1 rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) rd(3'(a), 4'h0);

    // wrap across the top with stalls between words
    wq = '{4'h5, 4'hC, 4'h2, 4'hF};
    burst(3'd6, 4'd4, 3);
    check("t3_accepts", acc, 4);
    check("t3_cycles", cyc, 13);
    rd(3'd6, 4'h5);
    rd(3'd7, 4'hC);
    rd(3'd0, 4'h2);
    rd(3'd1, 4'hF);
    rd(3'd2, 4'h0);
    rd(3'd5, 4'h0);

    // zero-length burst
    burst(3'd6, 4'd0, 0);
    check("len0_accepts", acc, 0);
    check("len0_cycles", cyc, 0);
    rd(3'd6, 4'h5);
    rd(3'd0, 4'h2);

    // over-length burst clamps to depth
    wq = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    burst(3'd0, 4'd12, 0);
    check("len12_accepts", acc, 8);
    check("len12_cycles", cyc, 8);
    rd(3'd0, 4'h8);
    rd(3'd7, 4'hF);

    // collisions: read during load, start during load, idle valid
    rd(3'd7, 4'hF);
    start      = 1'b1;
    start_addr = 3'd0;
    len        = 4'd3;
    tick();
    start    = 1'b0;
    en       = 1'b1;
    addr     = 3'd3;
    in_valid = 1'b1;
    in_data  = 4'h1;
    tick();
    check("ld_read_hold1", data_out, 4'hF);
    start      = 1'b1;
    start_addr = 3'd5;
    len        = 4'd1;
    in_data    = 4'h2;
    tick();
    start = 1'b0;
    check("ld_read_hold2", data_out, 4'hF);
    check("start_ignored", busy, 1);
    in_data = 4'h3;
    tick();
    in_valid = 1'b0;
    check("t5_done", done, 1);
    addr = 3'd2;
    tick();
    en = 1'b0;
    check("done_cycle_read", data_out, 4'h3);
    check("no_requeue", busy, 0);
    in_valid = 1'b1;
    in_data  = 4'h9;
    tick();
    tick();
    in_valid = 1'b0;
    check("idle_valid_busy", busy, 0);
    rd(3'd0, 4'h1);
    rd(3'd1, 4'h2);
    rd(3'd3, 4'hB);
    rd(3'd5, 4'hD);

    // reset in the middle of a burst
    start      = 1'b1;
    start_addr = 3'd0;
    len        = 4'd8;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'h7;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    check("mid_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_rdy", in_ready, 0);
    #1 rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) rd(3'(a), 4'h0);
    wq = '{4'h4, 4'h5};
    burst(3'd2, 4'd2, 0);
    check("t6_accepts", acc, 2);
    rd(3'd2, 4'h4);
    rd(3'd3, 4'h5);
    rd(3'd4, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
